// File: rtl/sum_game_ctrl.sv
// Sequencing controller for the Scrambled-Number SUM game: steers number loads,
// accumulates their sum, then scores player guesses against it.
module sum_game_ctrl #(
  parameter int N_NUMS    = 4,
  parameter int W         = 4,
  parameter int SUM_W     = 6,
  parameter int MAX_TRIES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      num_in,
  input  logic              num_valid,
  input  logic [SUM_W-1:0]  guess_in,
  input  logic              guess_valid,
  output logic [N_NUMS-1:0] ld_sel,
  output logic [SUM_W-1:0]  sum_out,
  output logic [2:0]        tries_left,
  output logic              busy,
  output logic              win,
  output logic              lose
);

  localparam int IDX_W = $clog2(N_NUMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NUMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GUESS,
    S_WIN,
    S_LOSE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [2:0]         tries_q, tries_d;
  logic               busy_q, busy_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    tries_d = tries_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          sum_d   = '0;
          tries_d = 3'(MAX_TRIES);
        end
      end
      S_LOAD: begin
        if (num_valid) begin
          sum_d = sum_q + SUM_W'(num_in);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_GUESS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_GUESS: begin
        if (guess_valid) begin
          if (guess_in == sum_q) begin
            state_d = S_WIN;
          end else if (tries_q > 3'd1) begin
            tries_d = tries_q - 3'd1;
          end else begin
            tries_d = '0;
            state_d = S_LOSE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are decoded from the next state so they flop alongside it.
    busy_d = (state_d == S_LOAD) || (state_d == S_GUESS);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      tries_q <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tries_q <= tries_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Load enable is combinational so the selected register captures num_in on this edge.
  always_comb begin
    ld_sel = '0;
    if (state_q == S_LOAD && num_valid) ld_sel[idx_q] = 1'b1;
  end

  assign sum_out    = sum_q;
  assign tries_left = tries_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule
